// File: rtl/run_detector_pkg.sv
// ---------------------------------------------------------------------------
// run_det_pkg
// Shared definitions for the serial run detector: the mode encodings seen on
// the mode input, the FSM state type, and a helper that decides whether the
// value of the current run is one the detector is looking for.
// ---------------------------------------------------------------------------
package run_det_pkg;

  // Selects which run values produce a detection
  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_ANY   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // IDLE: nothing sampled since reset, COUNT: run in progress without a hit,
  // HIT: the registered flag is asserted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2
  } state_t;

  // True when a run made of runValue counts as a detection under mode.
  // The disabled mode never qualifies, so a saturated run simply sits there.
  function automatic logic modeQualifies(input logic [1:0] mode,
                                         input logic       runValue);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_ONES:  ok = runValue;
      MODE_ZEROS: ok = ~runValue;
      MODE_ANY:   ok = 1'b1;
      MODE_OFF:   ok = 1'b0;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// ---------------------------------------------------------------------------
// run_detector_if
// Bundles the sample-side controls and the detector results of run_detector.
//   en        sample enable, the data bit is only looked at when high
//   mode      which run value is detected (see run_det_pkg)
//   retrig    1 = overlapping detection, 0 = run restarts after each hit
//   w         serial data bit
//   z         registered detect flag
//   match_cnt saturating number of detection events
//   run_len   current run length, saturating at RUN_LEN
//   last_val  value of the current run
// master: the stream source; slave: the detector.
// ---------------------------------------------------------------------------
interface run_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  logic             en;
  logic [1:0]       mode;
  logic             retrig;
  logic             w;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic [RUN_W-1:0] run_len;
  logic             last_val;

  modport master (
    output en, mode, retrig, w,
    input  z, match_cnt, run_len, last_val
  );

  modport slave (
    input  en, mode, retrig, w,
    output z, match_cnt, run_len, last_val
  );

endinterface

// File: rtl/run_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk_i  clock, rising edge
//   clr_i  synchronous clear, wins over everything else
//   en_i   counting enable
//   inc_i  request one increment (only honoured while en_i is high)
//   cnt_o  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: step by one unless every bit is already set, in which case
  // the counter stays pinned at its maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_detector.sv
// ---------------------------------------------------------------------------
// run_detector
// Watches a single-bit serial stream and raises a registered flag once
// RUN_LEN equal, qualifying samples have been seen in a row.
//   Clk  clock, all state changes on the rising edge
//   Rst  synchronous active-high reset, wins over the sample enable
//   bus  run_detector_if slave: en/mode/retrig/w in, z/match_cnt/run_len/
//        last_val out
// All outputs come straight from registers; nothing on the input side
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  run_detector_if.slave bus
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  // The run counter and the 8-bit style status fields only make sense for
  // runs of at least two samples and at most 255.
  generate
    if (RUN_LEN < 2 || RUN_LEN > 255) begin : gBadRunLen
      $error("run_detector: RUN_LEN must be within 2..255");
    end
  endgenerate

  state_t           state_q;
  state_t           state_d;
  logic [RUN_W-1:0] runLen_q;
  logic [RUN_W-1:0] runLen_d;
  logic             lastVal_q;
  logic             lastVal_d;
  logic             z_q;
  logic             z_d;

  logic [RUN_W-1:0] runNext;
  logic             qualify;
  logic             hit;
  logic             newArrival;
  logic [CNT_W-1:0] matchCnt;

  // Next-state logic. With the enable low every register holds, including
  // the flag. On an enabled edge the run either extends (same value, capped
  // at RUN_LEN) or restarts at one (first sample after reset or a value
  // change). Qualification looks at the value the run will have after this
  // edge, so a value change can never produce a hit on the same edge.
  // In non-overlapping mode a hit empties the run counter while keeping the
  // run value, so the next RUN_LEN equal samples form a fresh detection.
  // A hit only counts as a new event when the run was not already saturated,
  // which keeps an overlapping run from being counted more than once.
  always_comb begin
    state_d    = state_q;
    runLen_d   = runLen_q;
    lastVal_d  = lastVal_q;
    z_d        = z_q;
    runNext    = runLen_q;
    qualify    = 1'b0;
    hit        = 1'b0;
    newArrival = 1'b0;

    if (bus.en) begin
      if (state_q == IDLE || bus.w != lastVal_q) begin
        lastVal_d = bus.w;
        runNext   = RUN_W'(1);
      end else if (runLen_q == RUN_MAX) begin
        runNext = RUN_MAX;
      end else begin
        runNext = runLen_q + RUN_W'(1);
      end

      qualify    = modeQualifies(bus.mode, lastVal_d);
      hit        = (runNext == RUN_MAX) && qualify;
      newArrival = hit && (runLen_q != RUN_MAX);

      runLen_d = (hit && !bus.retrig) ? '0 : runNext;
      z_d      = hit;

      case (state_q)
        IDLE:    state_d = hit ? HIT : COUNT;
        COUNT:   state_d = hit ? HIT : COUNT;
        HIT:     state_d = hit ? HIT : COUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers. Reset discards any run in progress so the
  // next enabled sample starts from scratch.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      runLen_q  <= '0;
      lastVal_q <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      runLen_q  <= runLen_d;
      lastVal_q <= lastVal_d;
      z_q       <= z_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) uMatchCnt (
    .clk_i(Clk),
    .clr_i(Rst),
    .en_i (bus.en),
    .inc_i(newArrival),
    .cnt_o(matchCnt)
  );

  assign bus.z         = z_q;
  assign bus.match_cnt = matchCnt;
  assign bus.run_len   = runLen_q;
  assign bus.last_val  = lastVal_q;

endmodule

// File: tb/tb_run_detector.sv
// ---------------------------------------------------------------------------
// tb_run_detector
// Drives two detectors (RUN_LEN=4, one with an 8-bit and one with a 2-bit
// match counter) from the same stream and checks them against a reference
// model every cycle, plus literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_run_detector;

  localparam int RUN_LEN = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       retrig = 1'b1;
  logic       w = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  run_detector_if #(.RUN_LEN(RUN_LEN), .CNT_W(8)) busA ();
  run_detector_if #(.RUN_LEN(RUN_LEN), .CNT_W(2)) busB ();

  assign busA.en = en;
  assign busA.mode = mode;
  assign busA.retrig = retrig;
  assign busA.w = w;
  assign busB.en = en;
  assign busB.mode = mode;
  assign busB.retrig = retrig;
  assign busB.w = w;

  run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dutA (
    .Clk(Clk),
    .Rst(Rst),
    .bus(busA)
  );

  run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dutB (
    .Clk(Clk),
    .Rst(Rst),
    .bus(busB)
  );

  always #5 Clk = ~Clk;

  // Reference model state: plain integers describing the stream so far
  int mRun = 0;
  int mLast = 0;
  bit mStarted = 1'b0;
  int mZ = 0;
  int mCntA = 0;
  int mCntB = 0;

  task automatic compareVal(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic modelStep();
    int prevRun;
    bit qual;
    bit hit;
    if (Rst) begin
      mRun = 0;
      mLast = 0;
      mStarted = 1'b0;
      mZ = 0;
      mCntA = 0;
      mCntB = 0;
    end else if (en) begin
      prevRun = mRun;
      if (!mStarted || int'(w) != mLast) begin
        mLast = int'(w);
        mRun = 1;
        mStarted = 1'b1;
      end else begin
        mRun = (mRun + 1 > RUN_LEN) ? RUN_LEN : mRun + 1;
      end
      qual = (mode == 2'd0 && mLast == 1) || (mode == 2'd1 && mLast == 0) || (mode == 2'd2);
      hit = (mRun == RUN_LEN) && qual;
      if (hit && prevRun != RUN_LEN) begin
        if (mCntA < 255) mCntA++;
        if (mCntB < 3) mCntB++;
      end
      if (hit && !retrig) mRun = 0;
      mZ = hit ? 1 : 0;
    end
  endtask

  // Model update on each rising edge, DUT comparison on the following
  // falling edge when the registered outputs are stable.
  initial begin
    forever begin
      @(posedge Clk);
      modelStep();
      @(negedge Clk);
      compareVal("zA", int'(busA.z), mZ);
      compareVal("cntA", int'(busA.match_cnt), mCntA);
      compareVal("runLenA", int'(busA.run_len), mRun);
      compareVal("lastValA", int'(busA.last_val), mLast);
      compareVal("zB", int'(busB.z), mZ);
      compareVal("cntB", int'(busB.match_cnt), mCntB);
    end
  end

  // Drive one edge's worth of inputs and wait until the edge has passed
  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] m,
                               input bit rt, input bit wv);
    Rst = r;
    en = e;
    mode = m;
    retrig = rt;
    w = wv;
    @(negedge Clk);
  endtask

  // Apply n bits, most significant first, with enable high and reset low
  task automatic applyBits(input logic [15:0] bits, input int n,
                           input logic [1:0] m, input bit rt);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, m, rt, bits[n-1-i]);
    end
  endtask

  // Literal expectations for both the DUT and the model
  task automatic checkOutput(input string name, input int expZ, input int expCnt,
                             input int expRun, input int expCntB);
    compareVal({name, ".z"}, int'(busA.z), expZ);
    compareVal({name, ".cnt"}, int'(busA.match_cnt), expCnt);
    compareVal({name, ".run"}, int'(busA.run_len), expRun);
    compareVal({name, ".cntB"}, int'(busB.match_cnt), expCntB);
    compareVal({name, ".modelZ"}, mZ, expZ);
    compareVal({name, ".modelCnt"}, mCntA, expCnt);
    compareVal({name, ".modelRun"}, mRun, expRun);
    compareVal({name, ".modelCntB"}, mCntB, expCntB);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    bit rNew;
    bit eNew;
    logic [1:0] mNew;
    bit rtNew;
    bit wNew;

    // Reset and a basic overlapping run of ones
    doReset();
    checkOutput("reset", 0, 0, 0, 0);
    applyBits(16'b1111, 4, 2'b00, 1'b1);
    checkOutput("ones4", 1, 1, 4, 1);
    applyBits(16'b0, 1, 2'b00, 1'b1);
    checkOutput("drop", 0, 1, 1, 1);
    applyBits(16'b1, 1, 2'b00, 1'b1);
    checkOutput("restart", 0, 1, 1, 1);

    // Non-overlapping: two pulses from eight ones
    doReset();
    applyBits(16'b1111, 4, 2'b00, 1'b0);
    checkOutput("nonOvl4", 1, 1, 0, 1);
    applyBits(16'b1, 1, 2'b00, 1'b0);
    checkOutput("nonOvl5", 0, 1, 1, 1);
    applyBits(16'b111, 3, 2'b00, 1'b0);
    checkOutput("nonOvl8", 1, 2, 0, 2);

    // Overlapping: flag held, counted once
    doReset();
    applyBits(16'b11111111, 8, 2'b00, 1'b1);
    checkOutput("ovl8", 1, 1, 4, 1);

    // Runs of zeros, either value, and disabled detection
    doReset();
    applyBits(16'b0000, 4, 2'b01, 1'b1);
    checkOutput("zeros4", 1, 1, 4, 1);
    doReset();
    applyBits(16'b111000, 6, 2'b10, 1'b1);
    checkOutput("any6", 0, 0, 3, 0);
    applyBits(16'b0, 1, 2'b10, 1'b1);
    checkOutput("any7", 1, 1, 4, 1);
    doReset();
    applyBits(16'b11111, 5, 2'b11, 1'b1);
    checkOutput("off", 0, 0, 4, 0);

    // Sample enable holds the run
    doReset();
    applyBits(16'b11, 2, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("enHold", 0, 0, 2, 0);
    applyBits(16'b1, 1, 2'b00, 1'b1);
    checkOutput("enRe1", 0, 0, 3, 0);
    applyBits(16'b1, 1, 2'b00, 1'b1);
    checkOutput("enRe2", 1, 1, 4, 1);

    // Reset in the middle of a run discards it
    doReset();
    applyBits(16'b111, 3, 2'b00, 1'b1);
    doReset();
    applyBits(16'b111, 3, 2'b00, 1'b1);
    checkOutput("midReset", 0, 0, 3, 0);

    // Interrupted run
    doReset();
    applyBits(16'b110111, 6, 2'b00, 1'b1);
    checkOutput("brk6", 0, 0, 3, 0);
    applyBits(16'b1, 1, 2'b00, 1'b1);
    checkOutput("brk7", 1, 1, 4, 1);

    // Counter saturation on the narrow instance
    doReset();
    for (int i = 0; i < 20; i++) applyBits(16'b1, 1, 2'b00, 1'b0);
    checkOutput("sat20", 1, 5, 0, 3);

    // Randomised stream, checked every cycle by the compare process
    doReset();
    rtNew = 1'b1;
    mNew = 2'b00;
    wNew = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rNew = ($urandom_range(0, 149) == 0);
      eNew = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mNew = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rtNew = ~rtNew;
      if ($urandom_range(0, 3) == 0) wNew = ~wNew;
      applyStimulus(rNew, eNew, mNew, rtNew, wNew);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised serial run detector. It generalises the fixed-length consecutive-value FSM into a block with a configurable run length and value mode.
- Overlapping and non-overlapping detection are both supported, along with sample enable and a saturating match counter.
- It sits on a single-bit serial input stream, and its registered flag z feeds downstream control logic.

Parameters:
- RUN_LEN, 4, consecutive equal samples needed for a hit. Must be 2..255; values outside this range are flagged by an elaboration-time check.
- CNT_W, 8, width of match_cnt.
- RUN_W, derived localparam = clog2(RUN_LEN+1), width of run_len.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; w is evaluated only when en=1.
- mode  in  2  00 = detect runs of 1s, 01 = runs of 0s, 10 = runs of either value, 11 = detection disabled.
- retrig  in  1  1 = overlapping (z holds while run continues), 0 = non-overlapping (run restarts after each hit).
- w  in  1  serial data input.
- z  out  1  registered detect flag.
- match_cnt  out  CNT_W  saturating count of detection events.
- run_len  out  RUN_W  current run length, saturates at RUN_LEN.
- last_val  out  1  value of the current run.

Behaviour:
- Reset (Rst=1 at an edge):
  - z=0, match_cnt=0, run_len=0, last_val=0, state=IDLE.
  - Rst has priority over en.
  - Reset mid-run discards the run; the next enabled sample starts a new run.
- en=0: all registers hold, including z; no counting.
- States: IDLE (no sample since reset), COUNT (run in progress, z=0), HIT (z=1).
- run_next, per enabled edge:
  - IDLE: last_val<=w, run_next=1, go to COUNT.
  - w==last_val: run_next = min(run_len+1, RUN_LEN).
  - w!=last_val: last_val<=w, run_next=1.
- Qualify: value qualifies if mode=00 and last_val'=1, or mode=01 and last_val'=0, or mode=10. Mode 11 never qualifies. last_val' is the post-update value.
- hit = (run_next==RUN_LEN) and qualifies.
- Latency: z<=hit, visible from the edge that samples the completing bit. There are no combinational paths from inputs to outputs.
- retrig=1: run_len<=run_next. z stays 1 on every enabled edge while the run continues and still qualifies. z drops at the edge sampling a differing bit (run_len=1).
- retrig=0: on hit, run_len<=0 while last_val is kept. z is a one-cycle pulse at the enabled edge; the next enabled edge clears it. A run of 2*RUN_LEN equal bits gives two pulses.
- match_cnt:
  - Increments on an enabled edge where hit=1 and run_len!=RUN_LEN before the edge, i.e. a new arrival.
  - retrig=1 counts once per run; retrig=0 counts every pulse.
  - Saturates at all-ones and never wraps.
- State transitions:
  - COUNT->HIT on hit.
  - HIT->COUNT on !hit (enabled edge).
  - IDLE->COUNT on first enabled sample.
- Mode or retrig changes take effect at the next enabled edge. run_len is not cleared. A qualifying saturated run under retrig=1 re-asserts z but does not increment match_cnt.
- Simultaneous events: a value change on the same edge as saturation restarts the run, so there is no hit.

Decomposition:
- Package run_det_pkg holds:
  - mode encodings MODE_ONES=2'b00, MODE_ZEROS=2'b01, MODE_ANY=2'b10, MODE_OFF=2'b11;
  - state encodings IDLE/COUNT/HIT.
- One sub-module, sat_counter (parameter WIDTH; inputs clr, inc, en; saturating output), instantiated for match_cnt.
- The run-length logic stays inline because of its restart/saturate-at-RUN_LEN rules.

Test Plan (RUN_LEN=4, CNT_W=8):
- Rst=1 one edge, w=0 -> z=0, match_cnt=0, run_len=0. Then Rst=0, mode=00, retrig=1, en=1, w=1 for 4 edges -> z=1 after the 4th edge, match_cnt=1, run_len=4. Then w=0 -> z=0, run_len=1. Then w=1 -> run_len=1.
- mode=00, retrig=0, w=1 for 8 edges -> z pulses after edges 4 and 8 only, match_cnt=2, run_len=0 after edge 8. With retrig=1 the same stimulus gives z=1 on edges 4..8 and match_cnt=1.
- mode=01, w=0 for 4 edges -> z=1. mode=10 with 1110000 -> z=1 on the 7th edge. mode=11 with any stimulus -> z=0, match_cnt unchanged.
- w=1 for 2 edges, en=0 for 3 edges, en=1 with w=1 for 2 edges -> run_len holds at 2 while disabled, z=1 on the 2nd re-enabled edge.
- w=1 for 3 edges, Rst=1, then w=1 for 3 edges -> z stays 0, run_len=3. 1101111 -> z=1 only on the last edge.
- CNT_W=2, retrig=0, w=1 for 20 edges -> match_cnt = 1, 2, 3, 3, 3 (saturates, no wrap).
